// File: rtl/debounce_pkg.sv
// Shared types and default constants for the multi-channel debouncer.
// The optional auto-repeat feature is selected with the DEBOUNCE_REPEAT_EN macro.
package debounce_pkg;

    typedef enum logic [1:0] {
        LO     = 2'd0,
        ARM_HI = 2'd1,
        HI     = 2'd2,
        ARM_LO = 2'd3
    } state_t;

    localparam int DEF_STABLE_CYC = 8;
    localparam int DEF_REPEAT_DLY = 16;
    localparam int DEF_REPEAT_CYC = 4;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser, stability FSM with counter, registered strobes.
// Auto-repeat on press_pulse is compiled in only when DEBOUNCE_REPEAT_EN is defined.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int STABLE_CYC = DEF_STABLE_CYC,
    parameter int CNT_W      = $clog2(DEF_STABLE_CYC)
`ifdef DEBOUNCE_REPEAT_EN
    ,
    parameter int REPEAT_DLY = DEF_REPEAT_DLY,
    parameter int REPEAT_CYC = DEF_REPEAT_CYC
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic btn,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1;
    logic             s2;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_DLY);
    localparam logic [RPT_W-1:0] RPT_TERM   = RPT_W'(REPEAT_DLY - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DLY - REPEAT_CYC);
    localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);

    logic [RPT_W-1:0] rpt;
    logic             rpt_live;

    // Repeat runs while the level is held high, but not on the edge that drops it to LO.
    always_comb begin
        rpt_live = 1'b0;
        if (en) begin
            rpt_live = (state == HI) ||
                       ((state == ARM_LO) && !(!s2 && (cnt == CNT_TERM)));
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= LO;
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
            rpt           <= '0;
`endif
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (!en) begin
                state <= level ? HI : LO;
                cnt   <= '0;
            end else begin
                case (state)
                    LO: begin
                        if (s2) begin
                            state <= ARM_HI;
                            cnt   <= CNT_ONE;
                        end else begin
                            cnt   <= '0;
                        end
                    end
                    ARM_HI: begin
                        if (!s2) begin
                            state <= LO;
                            cnt   <= '0;
                        end else if (cnt == CNT_TERM) begin
                            state       <= HI;
                            level       <= 1'b1;
                            press_pulse <= 1'b1;
                            cnt         <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    HI: begin
                        if (!s2) begin
                            state <= ARM_LO;
                            cnt   <= CNT_ONE;
                        end else begin
                            cnt   <= '0;
                        end
                    end
                    ARM_LO: begin
                        if (s2) begin
                            state <= HI;
                            cnt   <= '0;
                        end else if (cnt == CNT_TERM) begin
                            state         <= LO;
                            level         <= 1'b0;
                            release_pulse <= 1'b1;
                            cnt           <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= LO;
                        cnt   <= '0;
                    end
                endcase
            end
`ifdef DEBOUNCE_REPEAT_EN
            // First strobe after REPEAT_DLY, then reload so the next lands REPEAT_CYC later.
            if (rpt_live) begin
                if (rpt == RPT_TERM) begin
                    press_pulse <= 1'b1;
                    rpt         <= RPT_RELOAD;
                end else begin
                    rpt <= rpt + RPT_ONE;
                end
            end else begin
                rpt <= '0;
            end
`endif
        end
    end

endmodule

// File: rtl/debounce_multi.sv
// N_CH independent debounce channels with a shared enable and parameter checks.
// Auto-repeat is enabled by defining DEBOUNCE_REPEAT_EN.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int STABLE_CYC = DEF_STABLE_CYC,
    parameter int CNT_W      = $clog2(STABLE_CYC),
    parameter int REPEAT_DLY = DEF_REPEAT_DLY,
    parameter int REPEAT_CYC = DEF_REPEAT_CYC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse
);

    if (N_CH < 1) begin : g_bad_nch
        $error("debounce_multi: N_CH must be at least 1");
    end
    if (STABLE_CYC < 2) begin : g_bad_stable
        $error("debounce_multi: STABLE_CYC must be at least 2");
    end
    if (CNT_W != $clog2(STABLE_CYC)) begin : g_bad_cntw
        $error("debounce_multi: CNT_W is derived and must not be overridden");
    end
    if (REPEAT_DLY < 2 || REPEAT_CYC < 1 || REPEAT_CYC > REPEAT_DLY) begin : g_bad_rpt
        $error("debounce_multi: need REPEAT_DLY >= 2 and 1 <= REPEAT_CYC <= REPEAT_DLY");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_chan #(
            .STABLE_CYC (STABLE_CYC),
            .CNT_W      (CNT_W)
`ifdef DEBOUNCE_REPEAT_EN
            ,
            .REPEAT_DLY (REPEAT_DLY),
            .REPEAT_CYC (REPEAT_CYC)
`endif
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .en            (en),
            .btn           (btn[i]),
            .level         (level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule
